// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the multi-channel IO space (io_space_mc).
//   - Word addresses of the register map.
//   - io_sel_t: which register a decoded address selects.
// ----------------------------------------------------------------------------
package io_pkg;

  // Word addresses of the register map.
  localparam int unsigned IO_OUT_BASE = 'h00;  // OUT[k] at IO_OUT_BASE + k
  localparam int unsigned IO_IN       = 'h10;
  localparam int unsigned IO_EDGE     = 'h11;
  localparam int unsigned IO_TIMER    = 'h12;
  localparam int unsigned IO_CMP      = 'h13;
  localparam int unsigned IO_STAT     = 'h14;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_OUT,
    SEL_IN,
    SEL_EDGE,
    SEL_TIMER,
    SEL_CMP,
    SEL_STAT
  } io_sel_t;

endpackage

// File: rtl/ffd.sv
// ----------------------------------------------------------------------------
// ffd
// Generic D flip-flop bank with a synchronous active-high reset and a load enable.
// Ports:
//   clk   in  1  clock
//   srst  in  1  synchronous reset, loads RST_VAL
//   en    in  1  load enable
//   d     in  W  next value
//   q     out W  registered value
// ----------------------------------------------------------------------------
module ffd #(
  parameter int          W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (srst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/io_in_sync.sv
// ----------------------------------------------------------------------------
// io_in_sync
// Synchroniser chain for asynchronous input pins plus a per-bit rising-edge pulse.
// Ports:
//   clk       in  1  clock
//   srst      in  1  synchronous reset (all chain flops to 0)
//   async_in  in  W  asynchronous pins
//   sync_out  out W  synchronised value (last chain stage)
//   rise      out W  1 for the cycle in which sync_out is about to go 0->1
// ----------------------------------------------------------------------------
module io_in_sync #(
  parameter int W      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         srst,
  input  logic [W-1:0] async_in,
  output logic [W-1:0] sync_out,
  output logic [W-1:0] rise
);

  // chain[0] is the raw pin value, chain[STAGES] the synchronised value.
  logic [STAGES:0][W-1:0] chain;

  assign chain[0] = async_in;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      ffd #(.W(W)) u_ff (
        .clk  (clk),
        .srst (srst),
        .en   (1'b1),
        .d    (chain[gi]),
        .q    (chain[gi+1])
      );
    end
  endgenerate

  assign sync_out = chain[STAGES];
  // Look one stage ahead so the edge flag is set on the same clock edge at
  // which the synchronised value becomes 1.
  assign rise = chain[STAGES-1] & ~chain[STAGES];

endmodule

// File: rtl/io_space_mc.sv
// ----------------------------------------------------------------------------
// io_space_mc
// Multi-channel IO space: decodes registered CPU IO requests into NUM_OUT output
// registers, a synchronised input port with rising-edge latch and (optionally) a
// free-running cycle timer with a compare interrupt. Read data is registered.
//
// Build option: define IO_TIMER_EN to implement TIMER/CMP/STAT and drive IRQ.
// Without it those addresses read 0, ignore writes (no IO_ERR) and IRQ is 0.
//
// Ports:
//   CLK       in   1              core clock
//   RESET     in   1              synchronous active-high reset
//   DBE       in   1              data bus error, cancels the request
//   IO_REQ    in   1              IO access request
//   IO_WE     in   1              write enable
//   IO_RE     in   1              read enable
//   IO_ADDR   in   RAM_DEPTH      word address
//   IO_WD     in   32             write data
//   IO_RD     out  32             registered read data
//   IO_RVAL   out  1              one-cycle strobe, IO_RD valid
//   IO_ERR    out  1              one-cycle strobe, unmapped address accessed
//   OUT_PINS  out  NUM_OUT*OUT_W  output registers, channel k at [k*OUT_W +: OUT_W]
//   IN_PINS   in   IN_W           asynchronous input pins
//   IRQ       out  1              timer compare hit pending
//
// Timing: request sampled at edge 1 (stage 1), committed at edge 2 (stage 2).
// ----------------------------------------------------------------------------
module io_space_mc
  import io_pkg::*;
#(
  parameter int RAM_DEPTH   = 14,
  parameter int NUM_OUT     = 4,
  parameter int OUT_W       = 8,
  parameter int IN_W        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     DBE,
  input  logic                     IO_REQ,
  input  logic                     IO_WE,
  input  logic                     IO_RE,
  input  logic [RAM_DEPTH-1:0]     IO_ADDR,
  input  logic [31:0]              IO_WD,
  output logic [31:0]              IO_RD,
  output logic                     IO_RVAL,
  output logic                     IO_ERR,
  output logic [NUM_OUT*OUT_W-1:0] OUT_PINS,
  input  logic [IN_W-1:0]          IN_PINS,
  output logic                     IRQ
);

  // --------------------------------------------------------------------------
  // Stage 1: register the whole request every cycle.
  // --------------------------------------------------------------------------
  localparam int PIPE_W = 4 + RAM_DEPTH + 32;

  logic [PIPE_W-1:0]    pipe_q;
  logic                 req_q, dbe_q, we_q, re_q;
  logic [RAM_DEPTH-1:0] addr_q;
  logic [31:0]          wd_q;

  ffd #(.W(PIPE_W)) u_stage1 (
    .clk  (CLK),
    .srst (RESET),
    .en   (1'b1),
    .d    ({IO_REQ, DBE, IO_WE, IO_RE, IO_ADDR, IO_WD}),
    .q    (pipe_q)
  );

  assign {req_q, dbe_q, we_q, re_q, addr_q, wd_q} = pipe_q;

  logic req_valid;
  logic wr;
  assign req_valid = req_q & ~dbe_q;
  assign wr        = req_valid & we_q;

  // --------------------------------------------------------------------------
  // Address decode on the stage-1 registers.
  // --------------------------------------------------------------------------
  io_sel_t sel;

  always_comb begin
    sel = SEL_NONE;
    if (addr_q < RAM_DEPTH'(IO_OUT_BASE + NUM_OUT)) begin
      sel = SEL_OUT;
    end else if (addr_q == RAM_DEPTH'(IO_IN)) begin
      sel = SEL_IN;
    end else if (addr_q == RAM_DEPTH'(IO_EDGE)) begin
      sel = SEL_EDGE;
    end else if (addr_q == RAM_DEPTH'(IO_TIMER)) begin
      sel = SEL_TIMER;
    end else if (addr_q == RAM_DEPTH'(IO_CMP)) begin
      sel = SEL_CMP;
    end else if (addr_q == RAM_DEPTH'(IO_STAT)) begin
      sel = SEL_STAT;
    end
  end

  // --------------------------------------------------------------------------
  // Output registers. The packed layout matches OUT_PINS directly.
  // --------------------------------------------------------------------------
  logic [NUM_OUT-1:0][OUT_W-1:0] out_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      logic out_we;
      assign out_we = wr && (sel == SEL_OUT)
                      && (addr_q == RAM_DEPTH'(IO_OUT_BASE + gi));
      ffd #(.W(OUT_W)) u_out (
        .clk  (CLK),
        .srst (RESET),
        .en   (out_we),
        .d    (wd_q[OUT_W-1:0]),
        .q    (out_q[gi])
      );
    end
  endgenerate

  assign OUT_PINS = out_q;

  // --------------------------------------------------------------------------
  // Input port and edge latch (RW1C; a new rising edge beats a same-cycle clear).
  // --------------------------------------------------------------------------
  logic [IN_W-1:0] in_sync;
  logic [IN_W-1:0] in_rise;
  logic [IN_W-1:0] edge_q;
  logic [IN_W-1:0] edge_clr;
  logic [IN_W-1:0] edge_next;

  io_in_sync #(.W(IN_W), .STAGES(SYNC_STAGES)) u_in_sync (
    .clk      (CLK),
    .srst     (RESET),
    .async_in (IN_PINS),
    .sync_out (in_sync),
    .rise     (in_rise)
  );

  assign edge_clr  = (wr && sel == SEL_EDGE) ? wd_q[IN_W-1:0] : '0;
  assign edge_next = (edge_q & ~edge_clr) | in_rise;

  ffd #(.W(IN_W)) u_edge (
    .clk  (CLK),
    .srst (RESET),
    .en   (1'b1),
    .d    (edge_next),
    .q    (edge_q)
  );

  // --------------------------------------------------------------------------
  // Optional timer with compare interrupt.
  // --------------------------------------------------------------------------
`ifdef IO_TIMER_EN
  logic [31:0] timer_q, timer_next;
  logic [31:0] cmp_q;
  logic        hit_q, hit_next;

  // A write to TIMER restarts it at 0 whatever the data.
  assign timer_next = (wr && sel == SEL_TIMER) ? 32'd0 : timer_q + 32'd1;

  // The compare looks at the current TIMER, so a match still sets hit even
  // when the same cycle clears TIMER; a set also overrides a STAT clear.
  always_comb begin
    hit_next = hit_q;
    if (wr && sel == SEL_STAT && wd_q[0]) begin
      hit_next = 1'b0;
    end
    if (timer_q == cmp_q) begin
      hit_next = 1'b1;
    end
  end

  ffd #(.W(32)) u_timer (
    .clk  (CLK),
    .srst (RESET),
    .en   (1'b1),
    .d    (timer_next),
    .q    (timer_q)
  );

  ffd #(.W(32), .RST_VAL({32{1'b1}})) u_cmp (
    .clk  (CLK),
    .srst (RESET),
    .en   (wr && sel == SEL_CMP),
    .d    (wd_q),
    .q    (cmp_q)
  );

  ffd #(.W(1)) u_hit (
    .clk  (CLK),
    .srst (RESET),
    .en   (1'b1),
    .d    (hit_next),
    .q    (hit_q)
  );

  assign IRQ = hit_q;
`else
  assign IRQ = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Readback mux (values before any same-cycle write) and stage-2 outputs.
  // --------------------------------------------------------------------------
  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_OUT: begin
        for (int k = 0; k < NUM_OUT; k++) begin
          if (addr_q == RAM_DEPTH'(IO_OUT_BASE + k)) begin
            rd_val[OUT_W-1:0] = out_q[k];
          end
        end
      end
      SEL_IN:    rd_val[IN_W-1:0] = in_sync;
      SEL_EDGE:  rd_val[IN_W-1:0] = edge_q;
`ifdef IO_TIMER_EN
      SEL_TIMER: rd_val = timer_q;
      SEL_CMP:   rd_val = cmp_q;
      SEL_STAT:  rd_val[0] = hit_q;
`endif
      default: ;
    endcase
  end

  logic rd_load;
  logic err_next;
  assign rd_load  = req_valid & re_q;
  assign err_next = req_valid & (we_q | re_q) & (sel == SEL_NONE);

  ffd #(.W(32)) u_rd (
    .clk  (CLK),
    .srst (RESET),
    .en   (rd_load),
    .d    (rd_val),
    .q    (IO_RD)
  );

  ffd #(.W(1)) u_rval (
    .clk  (CLK),
    .srst (RESET),
    .en   (1'b1),
    .d    (rd_load),
    .q    (IO_RVAL)
  );

  ffd #(.W(1)) u_err (
    .clk  (CLK),
    .srst (RESET),
    .en   (1'b1),
    .d    (err_next),
    .q    (IO_ERR)
  );

  // Upper write-data bits only matter for some registers in some builds.
  logic unused_wd;
  assign unused_wd = ^wd_q;

endmodule
